// File: rtl/sys_array_drain_accum.sv
// Drains a systolic array's skewed row outputs into a result matrix tile,
// either overwriting or accumulating into the stored values.
module sys_array_drain_accum #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 10,
  parameter int OUT_W      = 10,
  parameter int OUT_L      = 10,
  parameter int LAT        = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic                          clear,
  input  logic                          accumulate,
  input  logic [15:0]                   o_w0,
  input  logic [15:0]                   o_l0,
  input  logic [15:0]                   rows,
  input  logic [15:0]                   cols,
  input  logic signed [2*DATA_WIDTH-1:0] output_sys_array [0:ARRAY_W-1],
  output logic                          busy,
  output logic                          done,
  output logic signed [2*DATA_WIDTH-1:0] out_data [0:OUT_W-1][0:OUT_L-1]
);

  localparam int RW   = 2 * DATA_WIDTH;
  localparam int AIDX = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
  // Last WAIT count before CAPTURE; unused when LAT is 1 because WAIT is skipped.
  localparam logic [17:0] WAIT_LAST = 18'(LAT - 2);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic [17:0] k;
  logic [15:0] o_w0_q, o_l0_q, rows_q, cols_q;
  logic        acc_q;

  logic [15:0] rows_clamped;
  logic        tile_empty;
  logic [17:0] last_step;

  assign rows_clamped = (rows > 16'(ARRAY_W)) ? 16'(ARRAY_W) : rows;
  assign tile_empty   = (rows == 16'd0) || (cols == 16'd0);
  // Steps run k = 0 .. rows+cols-2; only meaningful for a non-empty tile.
  assign last_step    = {2'b00, rows_q} + {2'b00, cols_q} - 18'd2;

  assign busy = (state == S_WAIT) || (state == S_CAPTURE);
  assign done = (state == S_DONE);

  // Per matrix row: which array row feeds it (r = w - o_w0) and that row's sample.
  logic [17:0]   r_off  [0:OUT_W-1];
  logic          row_ok [0:OUT_W-1];
  logic [RW-1:0] sample [0:OUT_W-1];
  logic          hit    [0:OUT_W-1][0:OUT_L-1];

  for (genvar w = 0; w < OUT_W; w++) begin : g_row
    assign r_off[w]  = 18'(w) - {2'b00, o_w0_q};
    assign row_ok[w] = (state == S_CAPTURE) && (18'(w) >= {2'b00, o_w0_q}) &&
                       (r_off[w] < {2'b00, rows_q});
    assign sample[w] = output_sys_array[r_off[w][AIDX-1:0]];
    for (genvar l = 0; l < OUT_L; l++) begin : g_col
      logic [17:0] j_off;
      assign j_off     = 18'(l) - {2'b00, o_l0_q};
      // Element (w,l) is column j of row r, captured on the step where k = r + j.
      assign hit[w][l] = row_ok[w] && (18'(l) >= {2'b00, o_l0_q}) &&
                         (j_off < {2'b00, cols_q}) && ((r_off[w] + j_off) == k);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state: empty tiles jump straight to DONE, LAT==1 skips WAIT.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (tile_empty)    next_state = S_DONE;
          else if (LAT == 1) next_state = S_CAPTURE;
          else               next_state = S_WAIT;
        end
      end
      S_WAIT:    if (k == WAIT_LAST) next_state = S_CAPTURE;
      S_CAPTURE: if (k == last_step) next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Latch the tile description at start; k counts WAIT cycles, then capture steps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k      <= '0;
      o_w0_q <= '0;
      o_l0_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      acc_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k      <= '0;
            o_w0_q <= o_w0;
            o_l0_q <= o_l0;
            rows_q <= rows_clamped;
            cols_q <= cols;
            acc_q  <= accumulate;
          end
        end
        S_WAIT:    k <= (k == WAIT_LAST) ? 18'd0 : k + 18'd1;
        S_CAPTURE: k <= k + 18'd1;
        default:   k <= k;
      endcase
    end
  end

  // Result matrix: cleared by reset or an idle clear, otherwise written on capture hits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int w = 0; w < OUT_W; w++)
        for (int l = 0; l < OUT_L; l++)
          out_data[w][l] <= '0;
    end else if (state == S_IDLE && clear) begin
      for (int w = 0; w < OUT_W; w++)
        for (int l = 0; l < OUT_L; l++)
          out_data[w][l] <= '0;
    end else begin
      for (int w = 0; w < OUT_W; w++)
        for (int l = 0; l < OUT_L; l++)
          if (hit[w][l])
            out_data[w][l] <= acc_q ? (out_data[w][l] + sample[w]) : sample[w];
    end
  end

endmodule

// File: tb/tb_sys_array_drain_accum.sv
// Self-checking bench for sys_array_drain_accum: a reference matrix model plus
// a queue of expected done latencies checked as each tile completes.
module tb_sys_array_drain_accum;

  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int OW  = 10;
  localparam int OL  = 10;
  localparam int LAT = 2;

  typedef logic signed [2*DW-1:0] elem_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, clear, accumulate;
  logic [15:0] o_w0, o_l0, rows, cols;
  elem_t       output_sys_array [0:AW-1];
  logic        busy, done;
  elem_t       out_data [0:OW-1][0:OL-1];

  elem_t model [0:OW-1][0:OL-1];
  int    exp_lat_q[$];
  int    exp_busy_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;
  int    diff_n, diff_w, diff_l;

  sys_array_drain_accum #(
    .DATA_WIDTH(DW), .ARRAY_W(AW), .OUT_W(OW), .OUT_L(OL), .LAT(LAT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
    .accumulate(accumulate), .o_w0(o_w0), .o_l0(o_l0), .rows(rows),
    .cols(cols), .output_sys_array(output_sys_array), .busy(busy),
    .done(done), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic zero_model();
    for (int w = 0; w < OW; w++)
      for (int l = 0; l < OL; l++)
        model[w][l] = '0;
  endtask

  task automatic diff_matrix();
    diff_n = 0; diff_w = 0; diff_l = 0;
    for (int w = 0; w < OW; w++)
      for (int l = 0; l < OL; l++)
        if (out_data[w][l] !== model[w][l]) begin
          if (diff_n == 0) begin diff_w = w; diff_l = l; end
          diff_n++;
        end
  endtask

  // Present the values the array emits on capture step s; off-window rows carry junk.
  task automatic set_array(input int s, input int nr, input int nc, input int base, input int salt);
    for (int r = 0; r < AW; r++) begin
      if (r < nr && (s - r) >= 0 && (s - r) < nc)
        output_sys_array[r] = elem_t'(base + 10 * r + (s - r));
      else
        output_sys_array[r] = elem_t'(16'h6000 + r * 16 + salt);
    end
  endtask

  // Drive one tile from a negedge in IDLE; update the model, push expectations,
  // then monitor until done and score latency, busy span and pulse width.
  task automatic drive_tile(input string name, input int nr, input int nc, input int ow,
                            input int ol, input bit acc, input bit clr, input int base);
    int rc, m, e_lat, e_busy, obs_lat, obs_busy;
    rows = 16'(nr); cols = 16'(nc); o_w0 = 16'(ow); o_l0 = 16'(ol);
    accumulate = acc; clear = clr; start = 1'b1;
    set_array(-LAT, 0, 0, 0, 99);
    if (clr) zero_model();
    rc = (nr > AW) ? AW : nr;
    for (int r = 0; r < rc; r++)
      for (int j = 0; j < nc; j++)
        if (ow + r < OW && ol + j < OL) begin
          if (acc) model[ow + r][ol + j] = model[ow + r][ol + j] + elem_t'(base + 10 * r + j);
          else     model[ow + r][ol + j] = elem_t'(base + 10 * r + j);
        end
    m = (rc == 0 || nc == 0) ? 0 : LAT + rc + nc - 2;
    exp_lat_q.push_back(m);
    exp_busy_q.push_back(m);
    obs_lat = -1; obs_busy = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start = 1'b0; clear = 1'b0; rows = 16'd7; cols = 16'd9;
        o_w0 = 16'd0; o_l0 = 16'd0; accumulate = ~acc;
      end
      if (c == 1 && m >= 2) begin start = 1'b1; clear = 1'b1; end
      if (c == 2) begin start = 1'b0; clear = 1'b0; end
      if (busy === 1'b1) obs_busy++;
      if (done === 1'b1) begin obs_lat = c; break; end
      set_array(c + 1 - LAT, rc, nc, base, c);
    end
    start = 1'b0; clear = 1'b0;
    e_lat  = exp_lat_q.pop_front();
    e_busy = exp_busy_q.pop_front();
    tests_run++;
    if (obs_lat !== e_lat) begin
      tests_failed++;
      $display("[TB] FAIL %s done_latency: got %0d, want %0d", name, obs_lat, e_lat);
    end
    tests_run++;
    if (obs_busy !== e_busy) begin
      tests_failed++;
      $display("[TB] FAIL %s busy_cycles: got %0d, want %0d", name, obs_busy, e_busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL %s done_width: done got %b one cycle later, want 0", name, done);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; clear = 1'b0; accumulate = 1'b0;
    o_w0 = '0; o_l0 = '0; rows = '0; cols = '0;
    set_array(-100, 0, 0, 0, 0);
    zero_model();
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got busy=%b done=%b, want 0 0", busy, done);
    end
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_release_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    drive_tile("basic", 2, 3, 0, 0, 1'b0, 1'b0, 0);
    tests_run++;
    if (out_data[0][2] !== 16'sd2 || out_data[1][0] !== 16'sd10 || out_data[1][2] !== 16'sd12) begin
      tests_failed++;
      $display("[TB] FAIL basic_values: got %0d %0d %0d, want 2 10 12",
               out_data[0][2], out_data[1][0], out_data[1][2]);
    end
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL basic_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
  endtask

  task automatic test_accumulate();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    zero_model();
    drive_tile("acc_first", 2, 3, 0, 0, 1'b1, 1'b0, 0);
    drive_tile("acc_second", 2, 3, 0, 0, 1'b1, 1'b0, 0);
    tests_run++;
    if (out_data[1][2] !== 16'sd24 || out_data[0][1] !== 16'sd2) begin
      tests_failed++;
      $display("[TB] FAIL acc_values: got [1][2]=%0d [0][1]=%0d, want 24 2",
               out_data[1][2], out_data[0][1]);
    end
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL acc_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
  endtask

  task automatic test_wrap();
    drive_tile("wrap_seed", 1, 1, 0, 0, 1'b0, 1'b0, 32767);
    drive_tile("wrap_add", 1, 1, 0, 0, 1'b1, 1'b0, 1);
    tests_run++;
    if (out_data[0][0] !== 16'sh8000) begin
      tests_failed++;
      $display("[TB] FAIL wrap_value: got %0d, want -32768", out_data[0][0]);
    end
  endtask

  task automatic test_edge_clip();
    drive_tile("clip_rows", 3, 2, 9, 0, 1'b0, 1'b0, 200);
    drive_tile("clip_cols", 1, 4, 5, 8, 1'b0, 1'b0, 300);
    tests_run++;
    if (out_data[9][1] !== 16'sd201 || out_data[5][9] !== 16'sd301) begin
      tests_failed++;
      $display("[TB] FAIL clip_values: got [9][1]=%0d [5][9]=%0d, want 201 301",
               out_data[9][1], out_data[5][9]);
    end
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL clip_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
  endtask

  task automatic test_clamp();
    drive_tile("clamp", 40, 1, 0, 9, 1'b0, 1'b0, 100);
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL clamp_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
  endtask

  task automatic test_empty_and_clear();
    drive_tile("cols_zero", 2, 0, 0, 0, 1'b0, 1'b0, 500);
    drive_tile("rows_zero", 0, 3, 0, 0, 1'b0, 1'b0, 600);
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL empty_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    zero_model();
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL clear_matrix: %0d differ, [%0d][%0d] got %0d want 0",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l]);
    end
  endtask

  task automatic test_clear_start();
    drive_tile("cs_seed", 2, 2, 0, 0, 1'b0, 1'b0, 50);
    drive_tile("clear_start", 1, 2, 4, 4, 1'b1, 1'b1, 7);
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL clear_start_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    drive_tile("rm_seed", 2, 2, 6, 6, 1'b0, 1'b0, 70);
    rows = 16'd2; cols = 16'd3; o_w0 = 16'd0; o_l0 = 16'd0;
    accumulate = 1'b0; start = 1'b1;
    for (int r = 0; r < AW; r++) output_sys_array[r] = 16'sd55;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    zero_model();
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_flags: got busy=%b done=%b, want 0 0", busy, done);
    end
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_matrix: %0d differ, [%0d][%0d] got %0d want 0",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_no_done: got %0d busy/done cycles, want 0", pulses);
    end
    drive_tile("after_reset", 2, 3, 0, 0, 1'b0, 1'b0, 0);
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
  endtask

  task automatic test_back_to_back();
    drive_tile("b2b_first", 3, 2, 2, 2, 1'b0, 1'b0, 1);
    drive_tile("b2b_second", 2, 2, 2, 2, 1'b1, 1'b0, 40);
    diff_matrix();
    tests_run++;
    if (diff_n !== 0) begin
      tests_failed++;
      $display("[TB] FAIL b2b_matrix: %0d differ, [%0d][%0d] got %0d want %0d",
               diff_n, diff_w, diff_l, out_data[diff_w][diff_l], model[diff_w][diff_l]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_accumulate();
    test_wrap();
    test_edge_clip();
    test_clamp();
    test_empty_and_clear();
    test_clear_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
